// File: rtl/kpn_queue_arbiter.sv
// kpn_queue_arbiter
// Two producers share one FIFO token queue that feeds a single consumer.
// A round-robin arbiter picks at most one producer per cycle. Tokens
// therefore leave the queue in exactly the order they were granted.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high; discards all stored tokens
//   wr_req_a    producer A write request
//   data_a      producer A token
//   wr_req_b    producer B write request
//   data_b      producer B token
//   grant_a     combinational; A's token is written at the next edge
//   grant_b     combinational; B's token is written at the next edge
//   rd_req      consumer read request (blocking, no underflow)
//   data_out    registered token, holds its value between reads
//   data_valid  registered; high for one cycle per delivered token
//   full        count == 2**FIFO_ELEMENTS
//   empty       count == 0
//   count       number of stored tokens
module kpn_queue_arbiter #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req_a,
  input  logic [BITS_NUMBER-1:0]   data_a,
  input  logic                     wr_req_b,
  input  logic [BITS_NUMBER-1:0]   data_b,
  output logic                     grant_a,
  output logic                     grant_b,
  input  logic                     rd_req,
  output logic [BITS_NUMBER-1:0]   data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_ELEMENTS:0]   count
);

  localparam int DEPTH = 2 ** FIFO_ELEMENTS;
  localparam logic [FIFO_ELEMENTS:0]   CNT_ONE   = {{FIFO_ELEMENTS{1'b0}}, 1'b1};
  localparam logic [FIFO_ELEMENTS:0]   DEPTH_CNT = {1'b1, {FIFO_ELEMENTS{1'b0}}};
  localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE   = {{(FIFO_ELEMENTS-1){1'b0}}, 1'b1};

  logic [BITS_NUMBER-1:0]   mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] wr_ptr;
  logic [FIFO_ELEMENTS-1:0] rd_ptr;
  logic                     prio_b;   // 0: A wins a tie, 1: B wins a tie
  logic                     wr_en;
  logic                     rd_en;
  logic [BITS_NUMBER-1:0]   wr_data;

  // full/empty come from the registered count, so a same-cycle read never
  // frees a slot for a write and a same-cycle write never bypasses to a read.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // Grants are also forced low while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !full) begin
      if (wr_req_a && wr_req_b) begin
        grant_a = !prio_b;
        grant_b = prio_b;
      end else begin
        grant_a = wr_req_a;
        grant_b = wr_req_b;
      end
    end
  end

  assign wr_en   = grant_a | grant_b;
  assign rd_en   = rd_req & ~empty;
  assign wr_data = grant_b ? data_b : data_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prio_b     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_en;
      if (rd_en) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // Whoever was just served loses the next tie.
      if (grant_a) begin
        prio_b <= 1'b1;
      end else if (grant_b) begin
        prio_b <= 1'b0;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; empty=1 after reset keeps stale entries unreadable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_kpn_queue_arbiter.sv
module tb_kpn_queue_arbiter;

  logic        clk;
  logic        reset;
  logic        wr_req_a;
  logic [15:0] data_a;
  logic        wr_req_b;
  logic [15:0] data_b;
  logic        grant_a;
  logic        grant_b;
  logic        rd_req;
  logic [15:0] data_out;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  kpn_queue_arbiter #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req_a   (wr_req_a),
    .data_a     (data_a),
    .wr_req_b   (wr_req_b),
    .data_b     (data_b),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .rd_req     (rd_req),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Pops the scoreboard whenever the consumer side presents a token.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_token actual=%0h required=none", data_out);
        end else begin
          chk("token", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  endtask

  // Called at posedge+1: drive one cycle, check grants, push granted tokens.
  task automatic step(input logic ra, input logic [15:0] da,
                      input logic rb, input logic [15:0] db,
                      input logic rr, input logic ega, input logic egb,
                      input string tag);
    wr_req_a = ra;
    data_a   = da;
    wr_req_b = rb;
    data_b   = db;
    rd_req   = rr;
    @(negedge clk);
    chk({tag, "_grant_a"}, {31'h0, grant_a}, {31'h0, ega});
    chk({tag, "_grant_b"}, {31'h0, grant_b}, {31'h0, egb});
    if (ega) exp_q.push_back(da);
    if (egb) exp_q.push_back(db);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_cycles(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, "rd");
  endtask

  task automatic pulse_reset();
    exp_q.delete();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset    = 1'b1;
    wr_req_a = 1'b1;
    wr_req_b = 1'b1;
    data_a   = 16'h1234;
    data_b   = 16'h5678;
    rd_req   = 1'b1;
    #12;
    chk("rst_count", {26'h0, count}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_valid", {31'h0, data_valid}, 32'd0);
    chk("rst_data_out", {16'h0, data_out}, 32'h0);
    chk("rst_grant_a", {31'h0, grant_a}, 32'd0);
    chk("rst_grant_b", {31'h0, grant_b}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_req_a = 1'b0;
    wr_req_b = 1'b0;
    rd_req   = 1'b0;

    // Two writes from A then two reads.
    step(1'b1, 16'h0011, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "w034a");
    step(1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "w034b");
    chk("c034_count2", {26'h0, count}, 32'd2);
    rd_cycles(2);
    chk("c034_empty", {31'h0, empty}, 32'd1);
    chk("c034_valid_hi", {31'h0, data_valid}, 32'd1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "idle");
    chk("c034_valid_lo", {31'h0, data_valid}, 32'd0);
    chk("c034_data_hold", {16'h0, data_out}, 32'h0022);

    // Round-robin with both producers requesting; starts at A after reset.
    pulse_reset();
    step(1'b1, 16'hA000, 1'b1, 16'hB000, 1'b0, 1'b1, 1'b0, "rr1");
    step(1'b1, 16'hA001, 1'b1, 16'hB000, 1'b0, 1'b0, 1'b1, "rr2");
    step(1'b1, 16'hA001, 1'b1, 16'hB001, 1'b0, 1'b1, 1'b0, "rr3");
    step(1'b1, 16'hA002, 1'b1, 16'hB001, 1'b0, 1'b0, 1'b1, "rr4");
    chk("c035_count4", {26'h0, count}, 32'd4);
    rd_cycles(4);
    chk("c035_empty", {31'h0, empty}, 32'd1);

    // Fill to full, blocked request, read frees a slot only after the edge.
    for (int i = 0; i < 32; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "fill");
    chk("c036_full", {31'h0, full}, 32'd1);
    chk("c036_count32", {26'h0, count}, 32'd32);
    step(1'b1, 16'h3100, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "w33");
    chk("c036_count_hold", {26'h0, count}, 32'd32);
    step(1'b1, 16'h3101, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, "rdwr_full");
    chk("c036_count31", {26'h0, count}, 32'd31);
    chk("c036_not_full", {31'h0, full}, 32'd0);
    step(1'b1, 16'h3102, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "w_after");
    chk("c036_refill", {26'h0, count}, 32'd32);
    rd_cycles(32);
    chk("c036_drained", {26'h0, count}, 32'd0);

    // Write into an empty queue with a same-cycle read: no bypass.
    step(1'b1, 16'h5555, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, "nobypass");
    chk("c037_valid0", {31'h0, data_valid}, 32'd0);
    chk("c037_count1", {26'h0, count}, 32'd1);
    rd_cycles(1);
    chk("c037_valid1", {31'h0, data_valid}, 32'd1);
    chk("c037_data", {16'h0, data_out}, 32'h5555);

    // Streaming with interleaved reads; pointers wrap past 32.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        step(1'b1, 16'h6000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "strA");
      else
        step(1'b0, 16'h0, 1'b1, 16'h6000 + 16'(i), 1'b1, 1'b0, 1'b1, "strB");
    end
    chk("c038_count20", {26'h0, count}, 32'd20);
    rd_cycles(20);
    chk("c038_count0", {26'h0, count}, 32'd0);
    chk("c038_empty", {31'h0, empty}, 32'd1);

    // Mid-operation reset with count=10 and a token just delivered.
    for (int i = 0; i < 11; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "w039");
    wr_req_a = 1'b0;
    rd_req   = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("c039_count10", {26'h0, count}, 32'd10);
    chk("c039_valid_pre", {31'h0, data_valid}, 32'd1);
    #2;
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("c039_count0", {26'h0, count}, 32'd0);
    chk("c039_empty", {31'h0, empty}, 32'd1);
    chk("c039_valid0", {31'h0, data_valid}, 32'd0);
    chk("c039_data0", {16'h0, data_out}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 16'h8000, 1'b1, 16'h9000, 1'b0, 1'b1, 1'b0, "post_rst1");
    step(1'b1, 16'h8001, 1'b1, 16'h9000, 1'b0, 1'b0, 1'b1, "post_rst2");
    rd_cycles(2);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "idle");
    chk("end_count", {26'h0, count}, 32'd0);
    chk("end_scoreboard", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kpn_queue_arbiter.md
KPN_QUEUE_ARBITER -- requirements
Module: kpn_queue_arbiter

Interface
REQ-001 Parameter BITS_NUMBER, default 16, token data width.
REQ-002 Parameter FIFO_ELEMENTS, default 5, address width; the queue depth SHALL be 2**FIFO_ELEMENTS (32).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_req_a  input  1  producer A requests to write a token this cycle.
REQ-006 data_a  input  BITS_NUMBER  producer A token.
REQ-007 wr_req_b  input  1  producer B requests to write a token this cycle.
REQ-008 data_b  input  BITS_NUMBER  producer B token.
REQ-009 grant_a  output  1  combinational; producer A's token is written at the next rising edge.
REQ-010 grant_b  output  1  combinational; producer B's token is written at the next rising edge.
REQ-011 rd_req  input  1  consumer requests one token.
REQ-012 data_out  output  BITS_NUMBER  registered token delivered to the consumer.
REQ-013 data_valid  output  1  registered; data_out carries a new token this cycle.
REQ-014 full  output  1  count equals 2**FIFO_ELEMENTS.
REQ-015 empty  output  1  count equals 0.
REQ-016 count  output  FIFO_ELEMENTS+1  number of tokens stored.

Function
REQ-017 Storage: 2**FIFO_ELEMENTS x BITS_NUMBER register array; write pointer, read pointer and count SHALL all be registers.
REQ-018 Grant logic SHALL be combinational from wr_req_a, wr_req_b, full and the priority register; at most one grant SHALL be asserted per cycle.
REQ-019 If full=1, no grant SHALL be asserted.
REQ-020 With a single requester and full=0, that requester SHALL be granted.
REQ-021 With both requesting and full=0, the requester indicated by the priority register SHALL be granted. After any cycle with both requesting and one granted, the priority register SHALL move to the other producer (round-robin).
REQ-022 A single-requester grant SHALL set priority to the other producer.
REQ-023 A granted write SHALL store the granted data at the write pointer and increment the write pointer modulo 2**FIFO_ELEMENTS.
REQ-024 Read: if rd_req=1 and empty=0, the token at the read pointer SHALL appear on data_out at the next edge with data_valid=1 for exactly that cycle, and the read pointer SHALL increment modulo depth.
REQ-025 If rd_req=1 and empty=0 is false, data_valid SHALL be 0 and data_out SHALL hold its previous value. This is a blocking read, with no underflow.
REQ-026 Full and empty SHALL be evaluated on the pre-edge count. A write arriving while the queue is empty SHALL NOT bypass to a same-cycle read, and a read while the queue is full SHALL NOT free a slot for a same-cycle write.
REQ-027 Count SHALL increment on write only, decrement on read only, and stay unchanged on simultaneous write and read.
REQ-028 full and empty SHALL be derived from the registered count, giving single-cycle update latency.
REQ-029 Token order SHALL be preserved across pointer wrap-around.
REQ-030 Tokens SHALL be delivered in exact grant order (KPN determinism); no token SHALL be lost or duplicated.

Reset
REQ-031 While reset=1: pointers=0, count=0, empty=1, full=0, data_out=0, data_valid=0, priority=A, grant_a=grant_b=0.
REQ-032 Array contents SHALL be unspecified after reset and SHALL NOT be readable, since empty=1.
REQ-033 Reset asserted mid-operation SHALL discard all stored tokens immediately; the first post-reset grant with both requesting SHALL go to A.

Verification
REQ-034 Reset, then A writes 0x0011, 0x0022, then rd_req for 2 cycles -> data_out 0x0011 then 0x0022, data_valid high 2 cycles, empty=1 after.
REQ-035 A and B request continuously with A=0xA00n, B=0xB00n and rd_req=0, for 4 cycles -> grants A,B,A,B and count=4; reads return 0xA000,0xB000,0xA001,0xB001.
REQ-036 Fill 32 tokens -> full=1 and count=32. A 33rd request is not granted. A simultaneous read+request then yields no grant and count=31, and the next request is granted.
REQ-037 Empty queue with write and rd_req in the same cycle -> data_valid=0 that cycle. The next cycle's read returns the token with data_valid=1.
REQ-038 Stream 40 tokens with interleaved reads, wrapping the pointers -> output sequence equals input sequence and count returns to 0.
REQ-039 Assert reset with count=10 -> count=0, empty=1, data_valid=0 immediately (asynchronously), and priority returns to A.
